// File: rtl/full_adder_nb_pkg.sv
// Shared constants for the registered N-bit ripple-carry adder.
package full_adder_nb_pkg;

  localparam int unsigned ADDER_DEFAULT_WIDTH = 16;

endpackage

// File: rtl/full_adder_nb_if.sv
// Operand/result bundle for full_adder_nb; master drives operands, slave returns results.
interface full_adder_nb_if #(
  parameter int unsigned N = 16
);

  logic         in_valid;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic [N-1:0] sum;
  logic         cout;
  logic         overflow;
  logic         out_valid;

  modport master (
    output in_valid, a, b, cin,
    input  sum, cout, overflow, out_valid
  );

  modport slave (
    input  in_valid, a, b, cin,
    output sum, cout, overflow, out_valid
  );

endinterface

// File: rtl/full_adder_1b.sv
// One-bit full adder cell; the building block of the ripple chain.
module full_adder_1b (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;

  assign p  = a ^ b;
  assign s  = p ^ ci;
  assign co = (a & b) | (ci & p);

endmodule

// File: rtl/full_adder_nb.sv
// N-bit ripple-carry adder with carry-in, registered sum/carry/overflow and a valid qualifier.
module full_adder_nb
  import full_adder_nb_pkg::*;
#(
  parameter int unsigned N = ADDER_DEFAULT_WIDTH
) (
  input logic            clk,
  input logic            rst,
  full_adder_nb_if.slave bus
);

  logic [N:0]   carry;
  logic [N-1:0] sum_raw;

  logic [N-1:0] sum_d, sum_q;
  logic         cout_d, cout_q;
  logic         ovf_d, ovf_q;
  logic         valid_d, valid_q;

  assign carry[0] = bus.cin;

  for (genvar i = 0; i < N; i++) begin : g_ripple
    full_adder_1b u_fa (
      .a  (bus.a[i]),
      .b  (bus.b[i]),
      .ci (carry[i]),
      .s  (sum_raw[i]),
      .co (carry[i+1])
    );
  end

  // Result registers only load on qualified inputs, so idle operands never reach the outputs.
  always_comb begin
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    valid_d = bus.in_valid;
    if (bus.in_valid) begin
      sum_d  = sum_raw;
      cout_d = carry[N];
      ovf_d  = carry[N] ^ carry[N-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.overflow  = ovf_q;
  assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_full_adder_nb.sv
// Scoreboard bench driving 16-, 4- and 1-bit adders in lockstep from shared stimulus.
module tb_full_adder_nb;

  typedef struct packed {
    logic        v;
    logic [15:0] s;
    logic        c;
    logic        o;
  } exp_t;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  exp_t q16[$];
  exp_t q4[$];
  exp_t q1[$];
  exp_t last16, last4, last1;

  full_adder_nb_if #(.N(16)) bus16 ();
  full_adder_nb_if #(.N(4))  bus4 ();
  full_adder_nb_if #(.N(1))  bus1 ();

  full_adder_nb #(.N(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
  full_adder_nb #(.N(4))  u_dut4  (.clk(clk), .rst(rst), .bus(bus4));
  full_adder_nb #(.N(1))  u_dut1  (.clk(clk), .rst(rst), .bus(bus1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: wide integer add plus sign-rule overflow, masked to width w.
  function automatic exp_t next_exp(input int w, input logic r, input logic v,
                                    input logic [15:0] a, input logic [15:0] b,
                                    input logic ci, input exp_t last);
    exp_t        e;
    logic [16:0] m17;
    logic [15:0] m;
    logic [16:0] full;
    m17 = (17'd1 << w) - 17'd1;
    m   = m17[15:0];
    if (r) begin
      e = '0;
    end else if (!v) begin
      e   = last;
      e.v = 1'b0;
    end else begin
      full = {1'b0, a & m} + {1'b0, b & m} + {16'd0, ci};
      e.v  = 1'b1;
      e.s  = full[15:0] & m;
      e.c  = full[w];
      e.o  = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
    end
    return e;
  endfunction

  task automatic drive(input logic r, input logic v, input logic [15:0] a,
                       input logic [15:0] b, input logic ci);
    @(negedge clk);
    rst            = r;
    bus16.in_valid = v;
    bus16.a        = a;
    bus16.b        = b;
    bus16.cin      = ci;
    bus4.in_valid  = v;
    bus4.a         = a[3:0];
    bus4.b         = b[3:0];
    bus4.cin       = ci;
    bus1.in_valid  = v;
    bus1.a         = a[0];
    bus1.b         = b[0];
    bus1.cin       = ci;
    last16 = next_exp(16, r, v, a, b, ci, last16);
    last4  = next_exp(4,  r, v, a, b, ci, last4);
    last1  = next_exp(1,  r, v, a, b, ci, last1);
    q16.push_back(last16);
    q4.push_back(last4);
    q1.push_back(last1);
  endtask

  task automatic vec(input logic [15:0] a, input logic [15:0] b, input logic ci);
    drive(1'b0, 1'b1, a, b, ci);
  endtask

  task automatic cmp(input string tag, input exp_t e, input logic v, input logic [15:0] s,
                     input logic c, input logic o);
    check({tag, ".valid"}, {63'd0, v}, {63'd0, e.v});
    check({tag, ".sum"},   {48'd0, s}, {48'd0, e.s});
    check({tag, ".cout"},  {63'd0, c}, {63'd0, e.c});
    check({tag, ".ovf"},   {63'd0, o}, {63'd0, e.o});
  endtask

  // Outputs sampled 2 time units after each rising edge, one expectation per edge.
  always begin
    @(posedge clk);
    #2;
    if (q16.size() > 0) begin
      cmp("n16", q16.pop_front(), bus16.out_valid, bus16.sum, bus16.cout, bus16.overflow);
    end
    if (q4.size() > 0) begin
      cmp("n4", q4.pop_front(), bus4.out_valid, {12'd0, bus4.sum}, bus4.cout, bus4.overflow);
    end
    if (q1.size() > 0) begin
      cmp("n1", q1.pop_front(), bus1.out_valid, {15'd0, bus1.sum}, bus1.cout, bus1.overflow);
    end
  end

  initial begin
    rst            = 1'b1;
    bus16.in_valid = 1'b0;
    bus16.a        = '0;
    bus16.b        = '0;
    bus16.cin      = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.a         = '0;
    bus4.b         = '0;
    bus4.cin       = 1'b0;
    bus1.in_valid  = 1'b0;
    bus1.a         = '0;
    bus1.b         = '0;
    bus1.cin       = 1'b0;
    last16 = '0;
    last4  = '0;
    last1  = '0;

    // Reset wins over a valid all-ones operand pair.
    drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);
    drive(1'b1, 1'b1, 16'hFFFF, 16'hFFFF, 1'b1);

    vec(16'h0000, 16'h0000, 1'b0);
    vec(16'h0001, 16'h0001, 1'b0);
    vec(16'h00FF, 16'h0001, 1'b0);
    vec(16'h000F, 16'h00F0, 1'b1);
    vec(16'hAAAA, 16'h5555, 1'b1);
    vec(16'h7FFF, 16'h0001, 1'b1);
    vec(16'hFFFF, 16'hFFFF, 1'b1);

    // Hold: unqualified operands must not disturb the previous result.
    vec(16'h0003, 16'h0004, 1'b0);
    drive(1'b0, 1'b0, 16'h1234, 16'h1111, 1'b0);
    drive(1'b0, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1);

    // Mid-stream reset discards the in-flight result.
    vec(16'h1234, 16'h4321, 1'b1);
    drive(1'b1, 1'b1, 16'h0F0F, 16'h0F0F, 1'b0);
    vec(16'h0F0F, 16'h0F0F, 1'b0);

    // Exhaustive over the 4-bit (and hence 1-bit) space, back-to-back.
    for (int i = 0; i < 512; i++) begin
      logic [15:0] ai, bi;
      ai = 16'(i[3:0]) | 16'h5A50;
      bi = 16'(i[7:4]) | 16'hC3C0;
      vec(ai, bi, i[8]);
    end

    for (int i = 0; i < 10000; i++) begin
      drive(1'b0, ($urandom_range(9) != 0), 16'($urandom), 16'($urandom), 1'($urandom));
    end

    @(negedge clk);
    bus16.in_valid = 1'b0;
    bus4.in_valid  = 1'b0;
    bus1.in_valid  = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    check("drain", 64'(q16.size() + q4.size() + q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
